// File: rtl/ppc_pkg.sv
// ppc_pkg: op encoding and lane combine helpers for the prefix scan pipeline.
// Combine works on zero-extended PPC_MAX_W words; callers keep the low W bits, so ADD wraps mod 2^W.
package ppc_pkg;
   typedef enum logic [1:0] {PPC_ADD, PPC_MAXU, PPC_OR, PPC_XOR} ppc_op_e;
   localparam int PPC_MAX_W = 64;
   typedef logic [PPC_MAX_W-1:0] ppc_word_t;
   function automatic ppc_word_t ppc_combine(ppc_op_e op, ppc_word_t a, ppc_word_t b);
      return op == PPC_ADD  ? a + b :
             op == PPC_MAXU ? (a > b ? a : b) :
             op == PPC_OR   ? a | b : a ^ b;
   endfunction
   // Every op has an all-zero identity; MAXU is unsigned, so 0 is its floor.
   function automatic ppc_word_t ppc_identity(ppc_op_e op);
      return ppc_word_t'(op) & '0;
   endfunction
endpackage

// File: rtl/ppc_scan_level.sv
// ppc_scan_level: one Kogge-Stone combine level at lane distance DIST plus its stall-holding register.
module ppc_scan_level
   import ppc_pkg::*;
#(
   parameter int N     = 32,
   parameter int W     = 8,
   parameter int TAG_W = 32,
   parameter int DIST  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             in_valid,
   input  ppc_op_e          in_op,
   input  logic [N*W-1:0]   in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output ppc_op_e          out_op,
   output logic [N*W-1:0]   out_data,
   output logic [TAG_W-1:0] out_tag
);
   logic [N*W-1:0] comb;
   for (genvar i = 0; i < N; i++) begin : g_lane
      if (i < DIST) begin : g_pass
         assign comb[i*W +: W] = in_data[i*W +: W];
      end else begin : g_op
         assign comb[i*W +: W] = W'(ppc_combine(in_op, ppc_word_t'(in_data[i*W +: W]),
                                                ppc_word_t'(in_data[(i-DIST)*W +: W])));
      end
   end
   always_ff @(posedge clock)
      if (!reset) begin
         out_valid <= 1'b0;
         out_op    <= PPC_ADD;
         out_data  <= '0;
         out_tag   <= '0;
      end else if (!stall) begin
         out_valid <= in_valid;
         out_op    <= in_op;
         out_data  <= comb;
         out_tag   <= in_tag;
      end
endmodule

// File: rtl/ppc_scan_pipe.sv
// ppc_scan_pipe: pipelined Kogge-Stone inclusive scan over N lanes with valid/ready and a carried tag.
// Optional PPC_EXCL_EN adds in_excl, turning a transaction into an exclusive scan at the output.
module ppc_scan_pipe
   import ppc_pkg::*;
#(
   parameter int N     = 32,
   parameter int W     = 8,
   parameter int TAG_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   in_data,
   input  logic [1:0]       in_op,
`ifdef PPC_EXCL_EN
   input  logic             in_excl,
`endif
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N*W-1:0]   out_data,
   output logic [TAG_W-1:0] out_tag
);
   localparam int L = $clog2(N);
   logic             stall;
   logic             s0_valid;
   ppc_op_e          s0_op;
   logic [N*W-1:0]   s0_data;
   logic [TAG_W-1:0] s0_tag;
   logic             v [L+1];
   ppc_op_e          o [L+1];
   logic [N*W-1:0]   d [L+1];
   logic [TAG_W-1:0] t [L+1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v[L];
   assign out_tag   = t[L];
   always_ff @(posedge clock)
      if (!reset) begin
         s0_valid <= 1'b0;
         s0_op    <= PPC_ADD;
         s0_data  <= '0;
         s0_tag   <= '0;
      end else if (!stall) begin
         s0_valid <= in_valid;
         s0_op    <= ppc_op_e'(in_op);
         s0_data  <= in_data;
         s0_tag   <= in_tag;
      end
   assign v[0] = s0_valid;
   assign o[0] = s0_op;
   assign d[0] = s0_data;
   assign t[0] = s0_tag;
   for (genvar j = 0; j < L; j++) begin : g_level
      ppc_scan_level #(.N(N), .W(W), .TAG_W(TAG_W), .DIST(1 << j)) u_level (
         .clock(clock), .reset(reset), .stall(stall),
         .in_valid(v[j]), .in_op(o[j]), .in_data(d[j]), .in_tag(t[j]),
         .out_valid(v[j+1]), .out_op(o[j+1]), .out_data(d[j+1]), .out_tag(t[j+1])
      );
   end
`ifdef PPC_EXCL_EN
   // Exclusive flag rides alongside the levels; the output shifts the inclusive result up one lane.
   logic [L:0] x;
   always_ff @(posedge clock)
      if (!reset) x <= '0;
      else if (!stall) x <= {x[L-1:0], in_excl};
   assign out_data = x[L] ? {d[L][(N-1)*W-1:0], W'(ppc_identity(o[L]))} : d[L];
`else
   assign out_data = d[L];
`endif
endmodule

// File: tb/tb_ppc_scan_pipe.sv
// tb_ppc_scan_pipe: scoreboard bench for ppc_scan_pipe; expected scans come from a sequential lane model.
module tb_ppc_scan_pipe;
   localparam int N = 32, W = 8, TAG_W = 32, L = 5, NW = N * W;
   logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid;
   logic [NW-1:0] in_data = '0, out_data;
   logic [1:0] in_op = '0;
   logic [TAG_W-1:0] in_tag = '0, out_tag;
`ifdef PPC_EXCL_EN
   logic in_excl = 1'b0;
`endif
   always #5 clock = ~clock;
   ppc_scan_pipe #(.N(N), .W(W), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_op(in_op),
`ifdef PPC_EXCL_EN
      .in_excl(in_excl),
`endif
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );
   typedef struct {logic [NW-1:0] d; logic [TAG_W-1:0] t; int cyc; bit lat;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;
   bit was_stall = 0, acc;
   logic [NW-1:0] held_d;
   logic [TAG_W-1:0] held_t;
   logic [NW-1:0] sd [16];
   task automatic check(string tag, logic [NW-1:0] got, logic [NW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [NW-1:0] model(logic [1:0] op, logic [NW-1:0] din, bit ex);
      logic [W-1:0] a, x, r;
      logic [NW-1:0] res;
      a = '0;
      res = '0;
      for (int i = 0; i < N; i++) begin
         x = din[i*W +: W];
         case (op)
            2'd0: r = a + x;
            2'd1: r = (a > x) ? a : x;
            2'd2: r = a | x;
            default: r = a ^ x;
         endcase
         res[i*W +: W] = ex ? a : r;
         a = r;
      end
      return res;
   endfunction
   function automatic logic [NW-1:0] fill(logic [W-1:0] b);
      logic [NW-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = b;
      return r;
   endfunction
   function automatic logic [NW-1:0] rnd_data();
      logic [NW-1:0] r;
      for (int i = 0; i < NW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction
   task automatic monitor();
      exp_t e;
      if (!reset) begin
         was_stall = 0;
         return;
      end
      if (was_stall) begin
         check("stall_data", out_data, held_d);
         check("stall_tag", out_tag, held_t);
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) check("spurious_valid", out_valid, 1'b0);
         else begin
            e = q.pop_front();
            check("data", out_data, e.d);
            check("tag", out_tag, e.t);
            if (e.lat) check("latency", cyc - e.cyc, L + 1);
         end
      end
      was_stall = out_valid && !out_ready;
      held_d = out_data;
      held_t = out_tag;
      if (was_stall) check("in_ready_stall", in_ready, 1'b0);
   endtask
   task automatic cycle_io(input bit iv, input logic [1:0] op, input logic [NW-1:0] din,
                           input logic [TAG_W-1:0] tg, input bit ex, input bit ordy,
                           input bit lat, output bit accepted);
      @(negedge clock);
      cyc++;
      in_valid = iv;
      in_op = op;
      in_data = din;
      in_tag = tg;
      out_ready = ordy;
`ifdef PPC_EXCL_EN
      in_excl = ex;
`endif
      #1;
      monitor();
      accepted = iv && in_ready && reset;
      if (accepted) q.push_back('{d: model(op, din, ex), t: tg, cyc: cyc, lat: lat});
   endtask
   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle_io(1'b0, 2'd0, '0, '0, 1'b0, 1'b1, 1'b0, a);
   endtask
   task automatic send(input logic [1:0] op, input logic [NW-1:0] din, input logic [TAG_W-1:0] tg,
                       input bit ex, input bit lat, input bit rnd_rdy);
      bit a;
      int n;
      a = 0;
      n = 0;
      while (!a && n < 200) begin
         cycle_io(1'b1, op, din, tg, ex, rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, lat, a);
         n++;
      end
      if (!a) check("accept_timeout", n, 0);
   endtask
   initial begin
      logic [NW-1:0] mx, orv;
      int k, c;
      reset = 1'b0;
      idle(3);
      reset = 1'b1;
      idle(1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_tag", out_tag, '0);
      check("rst_in_ready", in_ready, 1'b1);
      send(2'd0, fill(8'h01), 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
      idle(8);
      send(2'd0, fill(8'hFF), 32'h0000_0002, 1'b0, 1'b1, 1'b0);
      idle(8);
      mx = fill(8'h03);
      mx[5*W +: W] = 8'h80;
      for (int i = 0; i < N; i++) orv[i*W +: W] = 8'(1 << (i % 8));
      send(2'd1, mx, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
      send(2'd2, orv, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
      send(2'd3, rnd_data(), 32'h0000_0005, 1'b0, 1'b1, 1'b0);
      send(2'd1, rnd_data(), 32'h0000_0006, 1'b0, 1'b1, 1'b0);
      idle(8);
      check("drain_basic", q.size(), 0);
      for (int i = 0; i < 16; i++) sd[i] = rnd_data();
      k = 0;
      c = 0;
      while (k < 16 && c < 100) begin
         cycle_io(1'b1, 2'(k), sd[k], 32'h100 + k, 1'b0, !(c >= 3 && c < 13), 1'b0, acc);
         if (acc) k++;
         c++;
      end
      check("stream_accepts", k, 16);
      idle(10);
      check("drain_stream", q.size(), 0);
      for (int i = 0; i < 3; i++) cycle_io(1'b1, 2'd0, rnd_data(), 32'h200 + i, 1'b0, 1'b1, 1'b0, acc);
      reset = 1'b0;
      idle(1);
      q.delete();
      reset = 1'b1;
      idle(1);
      check("post_rst_valid", out_valid, 1'b0);
      idle(10);
      for (int i = 0; i < 150; i++)
         send(2'($urandom_range(0, 3)), rnd_data(), $urandom, 1'b0, 1'b0, 1'b1);
`ifdef PPC_EXCL_EN
      send(2'd0, fill(8'h01), 32'h300, 1'b1, 1'b1, 1'b0);
      send(2'd3, rnd_data(), 32'h301, 1'b1, 1'b1, 1'b0);
      send(2'd1, rnd_data(), 32'h302, 1'b1, 1'b1, 1'b0);
      send(2'd2, rnd_data(), 32'h303, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++)
         send(2'($urandom_range(0, 3)), rnd_data(), $urandom, 1'($urandom), 1'b0, 1'b1);
`endif
      idle(20);
      check("drain_final", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
